// File: rtl/debug_fifo_pkg.sv
// Shared sizing helpers and types for the level-flag synchronous FIFO.
package debug_fifo_pkg;

    localparam int AF_OFFSET_DEF = 4;
    localparam int AE_TH_DEF     = 4;

    typedef enum logic [1:0] {
        ACC_NONE = 2'b00,
        ACC_RD   = 2'b01,
        ACC_WR   = 2'b10,
        ACC_BOTH = 2'b11
    } fifo_acc_e;

    function automatic int depth_of(input int w);
        return 1 << w;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n)
            r = r + 1;
        return r;
    endfunction

    function automatic int cnt_bits(input int w);
        return w + 1;
    endfunction

    function automatic int ptr_bits(input int w);
        return w;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// 2**W x B storage: synchronous write, asynchronous read, optional registered read port.
// SYNC_FIFO_LVL_REGOUT_EN selects the registered read path.
module fifo_dpram
    import debug_fifo_pkg::*;
#(
    parameter int B = 8,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [B-1:0] wdata,
    input  logic [W-1:0] raddr,
    output logic [B-1:0] rdata
);

    localparam int DEPTH = depth_of(W);

    logic [B-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

`ifdef SYNC_FIFO_LVL_REGOUT_EN
    // raddr is the next head address, so the flop tracks the head one cycle late at most
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end
`else
    assign rdata = mem[raddr];
`endif

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with occupancy count, level flags and error pulses.
// SYNC_FIFO_LVL_REGOUT_EN registers r_data; flags/count are identical either way.
module sync_fifo_lvl
    import debug_fifo_pkg::*;
#(
    parameter int B     = 8,
    parameter int W     = 5,
    parameter int AF_TH = depth_of(W) - AF_OFFSET_DEF,
    parameter int AE_TH = AE_TH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [W:0] DEPTH_C = (W+1)'(depth_of(W));
    localparam logic [W:0] AF_C    = (W+1)'(AF_TH);
    localparam logic [W:0] AE_C    = (W+1)'(AE_TH);
    localparam logic [W:0] ONE_C   = (W+1)'(1);

    logic [W-1:0] w_ptr;
    logic [W-1:0] r_ptr;
    logic [W-1:0] r_ptr_next;
    logic [W-1:0] rd_addr;
    logic [W:0]   count_next;
    logic         wr_acc;
    logic         rd_acc;
    fifo_acc_e    acc;

    // A full FIFO still takes a write when the head is popped in the same cycle
    assign wr_acc     = wr & (~full | rd);
    assign rd_acc     = rd & ~empty;
    assign acc        = fifo_acc_e'({wr_acc, rd_acc});
    assign r_ptr_next = rd_acc ? r_ptr + W'(1) : r_ptr;

    always_comb begin
        count_next = count;
        case (acc)
            ACC_WR:  count_next = count + ONE_C;
            ACC_RD:  count_next = count - ONE_C;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc)
                w_ptr <= w_ptr + W'(1);
            r_ptr        <= r_ptr_next;
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == DEPTH_C);
            almost_empty <= (count_next <= AE_C);
            almost_full  <= (count_next >= AF_C);
            overflow     <= wr & ~wr_acc;
            underflow    <= rd & ~rd_acc;
        end
    end

`ifdef SYNC_FIFO_LVL_REGOUT_EN
    assign rd_addr = r_ptr_next;
`else
    assign rd_addr = r_ptr;
`endif

    fifo_dpram #(
        .B (B),
        .W (W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (w_ptr),
        .wdata (w_data),
        .raddr (rd_addr),
        .rdata (r_data)
    );

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed self-checking bench for sync_fifo_lvl (B=8, W=2, AF_TH=3, AE_TH=1).
module tb_sync_fifo_lvl;

    logic       clk;
    logic       reset;
    logic       wr;
    logic [7:0] w_data;
    logic       rd;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    sync_fifo_lvl #(
        .B     (8),
        .W     (2),
        .AF_TH (3),
        .AE_TH (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one clock of stimulus, then leaves outputs ready to sample 1 time unit after the edge.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r);
        wr     = w;
        w_data = d;
        rd     = r;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wr = 1'b0; rd = 1'b0; w_data = '0;
        #3;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b expected 1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b expected 0", full); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae: got %b expected 1", almost_empty); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_af: got %b expected 0", almost_full); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_err: got ov=%b un=%b expected 0 0", overflow, underflow); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_fill;
        logic [7:0] data [4];
        logic [2:0] exp_cnt [4];
        logic       exp_ae [4];
        logic       exp_af [4];
        logic       exp_fu [4];
        data    = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4};
        exp_ae  = '{1'b1, 1'b0, 1'b0, 1'b0};
        exp_af  = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_fu  = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, data[i], 1'b0);
            total++; if (count !== exp_cnt[i]) begin bad++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, exp_cnt[i]); end
            total++; if (almost_empty !== exp_ae[i]) begin bad++; $display("FAIL fill_ae[%0d]: got %b expected %b", i, almost_empty, exp_ae[i]); end
            total++; if (almost_full !== exp_af[i]) begin bad++; $display("FAIL fill_af[%0d]: got %b expected %b", i, almost_full, exp_af[i]); end
            total++; if (full !== exp_fu[i]) begin bad++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, exp_fu[i]); end
            total++; if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty[%0d]: got %b expected 0", i, empty); end
        end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_d [4];
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        cycle(1'b1, 8'h55, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d expected 4", count); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b expected 1", full); end
        cycle(1'b0, 8'h00, 1'b0);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            total++; if (r_data !== exp_d[i]) begin bad++; $display("FAIL ovf_rdata[%0d]: got %h expected %h", i, r_data, exp_d[i]); end
            cycle(1'b0, 8'h00, 1'b1);
            total++; if (count !== 3'(3 - i)) begin bad++; $display("FAIL ovf_drain_count[%0d]: got %0d expected %0d", i, count, 3 - i); end
        end
        total++; if (empty !== 1'b1 || underflow !== 1'b0) begin bad++; $display("FAIL ovf_end: got empty=%b un=%b expected 1 0", empty, underflow); end
    endtask

    task automatic test_underflow;
        cycle(1'b0, 8'h00, 1'b1);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_pulse: got %b expected 1", underflow); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL unf_count: got %0d expected 0", count); end
        cycle(1'b0, 8'h00, 1'b0);
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_clear: got %b expected 0", underflow); end
        cycle(1'b1, 8'hA5, 1'b1);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_rw_pulse: got %b expected 1", underflow); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL unf_rw_count: got %0d expected 1", count); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL unf_rw_empty: got %b expected 0", empty); end
        cycle(1'b0, 8'h00, 1'b0);
        total++; if (r_data !== 8'hA5) begin bad++; $display("FAIL unf_rdata: got %h expected a5", r_data); end
        cycle(1'b0, 8'h00, 1'b1);
        total++; if (count !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL unf_drain: got count=%0d empty=%b expected 0 1", count, empty); end
    endtask

    task automatic test_full_rw;
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 8'(8'h01 + i), 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 8'(8'h60 + i), 1'b1);
            total++; if (full !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL fullrw[%0d]: got full=%b count=%0d expected 1 4", i, full, count); end
            total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL fullrw_err[%0d]: got ov=%b un=%b expected 0 0", i, overflow, underflow); end
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            total++; if (r_data !== 8'(8'h62 + i)) begin bad++; $display("FAIL fullrw_rdata[%0d]: got %h expected %h", i, r_data, 8'(8'h62 + i)); end
            cycle(1'b0, 8'h00, 1'b1);
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fullrw_end: got empty=%b expected 1", empty); end
    endtask

    task automatic test_wrap;
        for (int g = 0; g < 5; g++) begin
            cycle(1'b1, 8'(2 * g), 1'b0);
            cycle(1'b1, 8'(2 * g + 1), 1'b0);
            total++; if (count !== 3'd2) begin bad++; $display("FAIL wrap_count[%0d]: got %0d expected 2", g, count); end
            for (int k = 0; k < 2; k++) begin
                cycle(1'b0, 8'h00, 1'b0);
                total++; if (r_data !== 8'(2 * g + k)) begin bad++; $display("FAIL wrap_rdata[%0d]: got %h expected %h", 2 * g + k, r_data, 8'(2 * g + k)); end
                cycle(1'b0, 8'h00, 1'b1);
                total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL wrap_err[%0d]: got ov=%b un=%b expected 0 0", 2 * g + k, overflow, underflow); end
            end
        end
        total++; if (empty !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL wrap_end: got empty=%b count=%0d expected 1 0", empty, count); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        total++; if (count !== 3'd3 || almost_full !== 1'b1) begin bad++; $display("FAIL mid_pre: got count=%0d af=%b expected 3 1", count, almost_full); end
        #2 reset = 1'b1;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_count: got %0d expected 0", count); end
        total++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("FAIL mid_flags: got empty=%b ae=%b expected 1 1", empty, almost_empty); end
        total++; if (almost_full !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL mid_af: got af=%b full=%b expected 0 0", almost_full, full); end
        @(posedge clk);
        #1 reset = 1'b0;
        cycle(1'b1, 8'h7E, 1'b0);
        total++; if (count !== 3'd1) begin bad++; $display("FAIL mid_wr_count: got %0d expected 1", count); end
        cycle(1'b0, 8'h00, 1'b0);
        total++; if (r_data !== 8'h7E) begin bad++; $display("FAIL mid_rdata: got %h expected 7e", r_data); end
        cycle(1'b0, 8'h00, 1'b1);
        total++; if (empty !== 1'b1 || underflow !== 1'b0) begin bad++; $display("FAIL mid_end: got empty=%b un=%b expected 1 0", empty, underflow); end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_overflow;
        test_underflow;
        test_full_rw;
        test_wrap;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
